// File: rtl/bit_packer.sv
// rtl/bit_packer.sv - packs variable-length left-aligned chunks into fixed-width output words
module bit_packer #(
    parameter int DATA_IN_WIDTH = 64,
    parameter int LEN_IN_WIDTH  = 8,
    parameter int OUT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [DATA_IN_WIDTH-1:0] dataIn,
    input  logic [LEN_IN_WIDTH-1:0]  inLen,
    input  logic                     inLast,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [OUT_WIDTH-1:0]     dataOut,
    output logic                     outLast
);

    localparam int BUF_W  = 2 * DATA_IN_WIDTH;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam logic [FILL_W-1:0]       OUT_W_F = FILL_W'(OUT_WIDTH);
    localparam logic [FILL_W-1:0]       DIN_W_F = FILL_W'(DATA_IN_WIDTH);
    localparam logic [LEN_IN_WIDTH-1:0] DIN_W_L = LEN_IN_WIDTH'(DATA_IN_WIDTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                    state, stateNext;
    logic [BUF_W-1:0]          bitBuf, bufNext, bufPop;
    logic [FILL_W-1:0]         fill, fillNext, fillPop;
    logic [LEN_IN_WIDTH-1:0]   lenEff;
    logic [DATA_IN_WIDTH-1:0]  chunkMask;
    logic                      push, pop;

    assign inReady  = (state == RUN) && (fill <= DIN_W_F);
    assign outValid = (state == FLUSH) || (fill >= OUT_W_F);
    assign outLast  = (state == FLUSH) && (fill <= OUT_W_F);
    assign dataOut  = bitBuf[BUF_W-1 -: OUT_WIDTH];
    assign push     = inValid && inReady;
    assign pop      = outValid && outReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            bitBuf <= '0;
            fill   <= '0;
        end else begin
            state  <= stateNext;
            bitBuf <= bufNext;
            fill   <= fillNext;
        end
    end

    always_comb begin
        lenEff    = (inLen > DIN_W_L) ? DIN_W_L : inLen;
        // Upstream padding below the valid bits is never trusted
        chunkMask = ~({DATA_IN_WIDTH{1'b1}} >> lenEff);
        bufPop    = bitBuf;
        fillPop   = fill;
        stateNext = state;

        if (pop) begin
            bufPop  = bitBuf << OUT_WIDTH;
            fillPop = (fill >= OUT_W_F) ? fill - OUT_W_F : '0;
        end

        bufNext  = bufPop;
        fillNext = fillPop;

        // Push only happens in RUN with fill <= DATA_IN_WIDTH, so the chunk always fits
        if (push) begin
            bufNext  = bufPop | ({dataIn & chunkMask, {DATA_IN_WIDTH{1'b0}}} >> fillPop);
            fillNext = fillPop + FILL_W'(lenEff);
            if (inLast) begin
                stateNext = FLUSH;
            end
        end

        if (pop && outLast) begin
            stateNext = RUN;
        end
    end

endmodule
